// File: rtl/fitbit_pkg.sv
// ============================================================================
// Module : fitbit_pkg
// Brief  : Shared constants, segment table and conversion state type for the
//          step-tracker seven-segment display driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fitbit_pkg;

    localparam logic [6:0]  SEG_BLANK   = 7'h7F;
    localparam logic [15:0] MAX_DISPLAY = 16'd9999;

    // Active-low {g,f,e,d,c,b,a}; element 0 is the pattern for digit 0.
    localparam logic [9:0][6:0] SEG_LUT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] pat;
        pat = SEG_BLANK;
        if (nib <= 4'd9) begin
            pat = SEG_LUT[nib];
        end
        return pat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module : bin2bcd_seq
// Brief  : Sequential double-dabble: one capture cycle, 16 shift cycles and
//          one latch cycle per conversion.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import fitbit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] bin_in,
    input  logic        start,
    output logic        busy,
    output logic [15:0] bcd_out,
    output logic        done
);

    conv_state_t r_state;
    logic [31:0] r_shift;
    logic [3:0]  r_iter;
    logic        r_busy;
    logic        r_done;
    logic [31:0] w_adj;

    // Upper 16 bits hold the four BCD nibbles, lower 16 the binary being shifted in.
    always_comb begin
        w_adj = r_shift;
        for (int k = 0; k < 4; k++) begin
            if (r_shift[16 + 4*k +: 4] >= 4'd5) begin
                w_adj[16 + 4*k +: 4] = r_shift[16 + 4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift <= {18'd0, bin_in};
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= {w_adj[30:0], 1'b0};
                    r_iter  <= r_iter + 4'd1;
                    if (r_iter == 4'd15) begin
                        r_done  <= 1'b1;
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_shift[31:16];

endmodule

`default_nettype wire

// File: rtl/fitbit_seg_driver.sv
// ============================================================================
// Module : fitbit_seg_driver
// Brief  : Converts the tracker display value to BCD and scans it onto a
//          4-digit multiplexed common-anode seven-segment display.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fitbit_seg_driver
    import fitbit_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] display,
    input  logic        is_miles,
    input  logic        SI,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        si_led,
    output logic        conv_busy
);

    localparam int              CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [13:0]      w_bin;
    logic             w_busy;
    logic             w_done;
    logic [15:0]      w_bcd;

    logic             r_miles_cap;
    logic             r_miles;
    logic [15:0]      r_digits;
    logic [CNT_W-1:0] r_refresh_cnt;
    logic [1:0]       r_digit_sel;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_si_led;

    logic             w_wrap;
    logic [1:0]       w_sel_next;
    logic [15:0]      w_digits_next;
    logic             w_miles_next;
    logic [3:0]       w_nib;
    logic [3:0]       w_lz;
    logic [6:0]       w_seg_next;

    assign w_bin = (display > MAX_DISPLAY) ? MAX_DISPLAY[13:0] : display[13:0];

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .reset   (reset),
        .bin_in  (w_bin),
        .start   (1'b1),
        .busy    (w_busy),
        .bcd_out (w_bcd),
        .done    (w_done)
    );

    // Outputs are built from next-state values so a latch or wrap shows on the same edge.
    always_comb begin
        w_wrap        = (r_refresh_cnt == C_CNT_MAX);
        w_sel_next    = w_wrap ? r_digit_sel + 2'd1 : r_digit_sel;
        w_digits_next = w_done ? w_bcd : r_digits;
        w_miles_next  = w_done ? r_miles_cap : r_miles;
        w_nib         = w_digits_next[{w_sel_next, 2'b00} +: 4];
        w_lz[3]       = (w_digits_next[15:12] == 4'd0);
        w_lz[2]       = w_lz[3] && (w_digits_next[11:8] == 4'd0);
        w_lz[1]       = w_lz[2] && (w_digits_next[7:4] == 4'd0);
        w_lz[0]       = 1'b0;
        w_seg_next    = ((BLANK_LZ != 0) && w_lz[w_sel_next]) ? SEG_BLANK : seg_encode(w_nib);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_miles_cap   <= 1'b0;
            r_miles       <= 1'b0;
            r_digits      <= '0;
            r_refresh_cnt <= '0;
            r_digit_sel   <= 2'd0;
            r_an          <= 4'b1111;
            r_seg         <= SEG_BLANK;
            r_dp          <= 1'b1;
            r_si_led      <= 1'b0;
        end else begin
            if (!w_busy) begin
                r_miles_cap <= is_miles;
            end
            r_digits      <= w_digits_next;
            r_miles       <= w_miles_next;
            r_refresh_cnt <= w_wrap ? '0 : r_refresh_cnt + 1'b1;
            r_digit_sel   <= w_sel_next;
            r_an          <= ~(4'b0001 << w_sel_next);
            r_seg         <= w_seg_next;
            r_dp          <= !((w_sel_next == 2'd0) && w_miles_next);
            r_si_led      <= SI;
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = r_dp;
    assign si_led    = r_si_led;
    assign conv_busy = w_busy & ~w_done;

endmodule

`default_nettype wire

// File: tb/tb_fitbit_seg_driver.sv
// ============================================================================
// Module : tb_fitbit_seg_driver
// Brief  : Directed bench for fitbit_seg_driver with blanking on and off.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fitbit_seg_driver;

    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S1 = 7'h79;
    localparam logic [6:0] S2 = 7'h24;
    localparam logic [6:0] S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12;
    localparam logic [6:0] S7 = 7'h78;
    localparam logic [6:0] S9 = 7'h10;
    localparam logic [6:0] SB = 7'h7F;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] display;
    logic        is_miles;
    logic        SI;
    logic [3:0]  an,   an_b;
    logic [6:0]  seg,  seg_b;
    logic        dp,   dp_b;
    logic        si_led, si_led_b;
    logic        conv_busy, conv_busy_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    fitbit_seg_driver #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .reset(reset), .display(display), .is_miles(is_miles), .SI(SI),
        .an(an), .seg(seg), .dp(dp), .si_led(si_led), .conv_busy(conv_busy)
    );

    fitbit_seg_driver #(.REFRESH_DIV(4), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .reset(reset), .display(display), .is_miles(is_miles), .SI(SI),
        .an(an_b), .seg(seg_b), .dp(dp_b), .si_led(si_led_b), .conv_busy(conv_busy_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one edge after the LATCH edge, i.e. with freshly latched digits shown.
    task automatic wait_latch();
        bit seen_busy = 1'b0;
        bit ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            step();
            if (conv_busy) seen_busy = 1'b1;
            else if (seen_busy) ok = 1'b1;
        end
        check_val("latch_timeout", {31'd0, ok}, 32'd1);
        step();
    endtask

    // Watches one full scan; exp/exp_nb packed {d3,d2,d1,d0}.
    task automatic check_frame(input string tag, input logic [27:0] exp,
                               input logic [27:0] exp_nb, input logic miles);
        int prev = -1;
        for (int c = 0; c < 16; c++) begin
            int idx;
            idx = -1;
            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            check_val({tag, "_an_valid"}, {31'd0, idx >= 0}, 32'd1);
            if (idx >= 0) begin
                check_val({tag, "_seg"}, {25'd0, seg}, {25'd0, exp[idx*7 +: 7]});
                check_val({tag, "_seg_nb"}, {25'd0, seg_b}, {25'd0, exp_nb[idx*7 +: 7]});
                check_val({tag, "_an_nb"}, {28'd0, an_b}, {28'd0, an});
                check_val({tag, "_dp"}, {31'd0, dp}, {31'd0, !(idx == 0 && miles)});
                if (prev >= 0 && idx != prev)
                    check_val({tag, "_an_order"}, idx, (prev + 1) % 4);
                prev = idx;
            end
            step();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_an"}, {28'd0, an}, 32'hF);
        check_val({tag, "_seg"}, {25'd0, seg}, 32'h7F);
        check_val({tag, "_dp"}, {31'd0, dp}, 32'd1);
        check_val({tag, "_si_led"}, {31'd0, si_led}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, conv_busy}, 32'd0);
    endtask

    // Releases reset and checks the first LATCH lands 18 cycles later.
    task automatic release_and_time(input string tag);
        int n = 0;
        reset = 1'b0;
        step();
        check_val({tag, "_busy_e0"}, {31'd0, conv_busy}, 32'd1);
        while (conv_busy && n < 40) begin
            step();
            n++;
        end
        check_val({tag, "_latency"}, n, 16);
        step();
    endtask

    initial begin
        reset    = 1'b1;
        display  = 16'd1234;
        is_miles = 1'b0;
        SI       = 1'b0;
        repeat (3) step();
        check_reset_outputs("rst0");

        release_and_time("rel0");
        check_frame("f1234", {S1, S2, S3, S4}, {S1, S2, S3, S4}, 1'b0);

        // Reset mid-SHIFT with SI high: si_led must still clear.
        SI = 1'b1;
        wait_latch();
        repeat (4) step();
        check_val("mid_busy", {31'd0, conv_busy}, 32'd1);
        reset = 1'b1;
        step();
        check_reset_outputs("rst_mid");
        repeat (2) step();
        release_and_time("rel1");
        check_val("si_after_rel", {31'd0, si_led}, 32'd1);
        check_frame("f1234b", {S1, S2, S3, S4}, {S1, S2, S3, S4}, 1'b0);

        // si_led is a one-cycle delayed copy of SI.
        SI = 1'b0;
        step();
        check_val("si_low", {31'd0, si_led}, 32'd0);
        SI = 1'b1;
        #1;
        check_val("si_not_yet", {31'd0, si_led}, 32'd0);
        step();
        check_val("si_rise", {31'd0, si_led}, 32'd1);

        display = 16'd50000;
        wait_latch(); wait_latch();
        check_frame("f50000", {S9, S9, S9, S9}, {S9, S9, S9, S9}, 1'b0);
        SI = 1'b0;

        display = 16'd9999;
        wait_latch(); wait_latch();
        check_frame("f9999", {S9, S9, S9, S9}, {S9, S9, S9, S9}, 1'b0);
        display = 16'd10000;
        wait_latch(); wait_latch();
        check_frame("f10000", {S9, S9, S9, S9}, {S9, S9, S9, S9}, 1'b0);
        display = 16'd65535;
        wait_latch(); wait_latch();
        check_frame("f65535", {S9, S9, S9, S9}, {S9, S9, S9, S9}, 1'b0);

        display = 16'd7;
        wait_latch(); wait_latch();
        check_frame("f7", {SB, SB, SB, S7}, {S0, S0, S0, S7}, 1'b0);
        display = 16'd0;
        wait_latch(); wait_latch();
        check_frame("f0", {SB, SB, SB, S0}, {S0, S0, S0, S0}, 1'b0);
        display = 16'd1005;
        wait_latch(); wait_latch();
        check_frame("f1005", {S1, S0, S0, S5}, {S1, S0, S0, S5}, 1'b0);

        // Unit marker, then is_miles toggled mid-SHIFT.
        display  = 16'd3;
        is_miles = 1'b1;
        wait_latch(); wait_latch();
        check_frame("f3m", {SB, SB, SB, S3}, {S0, S0, S0, S3}, 1'b1);
        wait_latch();
        repeat (3) step();
        is_miles = 1'b0;
        wait_latch();
        check_frame("f3m_hold", {SB, SB, SB, S3}, {S0, S0, S0, S3}, 1'b1);
        wait_latch();
        check_frame("f3_off", {SB, SB, SB, S3}, {S0, S0, S0, S3}, 1'b0);

        // display changed mid-SHIFT: the in-flight value latches intact.
        display = 16'd1111;
        wait_latch(); wait_latch();
        wait_latch();
        repeat (3) step();
        display = 16'd2222;
        wait_latch();
        check_frame("f1111", {S1, S1, S1, S1}, {S1, S1, S1, S1}, 1'b0);
        wait_latch();
        check_frame("f2222", {S2, S2, S2, S2}, {S2, S2, S2, S2}, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
